// File: rtl/xoodyak_host_adapter.sv
// Host-side initiator for the Xoodyak hash core byte interface: buffers a whole
// message, starts the core, streams bytes under core_busy and assembles the digest.
module xoodyak_host_adapter #(
  parameter int MAX_LEN    = 64,
  parameter int HASH_BYTES = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  input  logic [11:0]             cmd_len,
  output logic                    cmd_ready,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    core_start,
  output logic [11:0]             core_msg_len,
  output logic [7:0]              core_msg,
  input  logic                    core_busy,
  input  logic [7:0]              core_hash,
  input  logic                    core_valid,
  output logic [8*HASH_BYTES-1:0] digest,
  output logic                    digest_valid,
  input  logic                    digest_ack,
  output logic                    err
);

  localparam int LEN_W  = 12;
  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam int HC_W   = $clog2(HASH_BYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int DIG_W  = 8 * HASH_BYTES;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [HC_W-1:0]  HC_LAST   = HC_W'(HASH_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_LOAD,
    S_WAIT_HASH,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_wr_idx;
  logic [IDX_W-1:0]   r_rd_idx;
  logic [HC_W-1:0]    r_hash_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [DIG_W-1:0]   r_digest;
  logic               r_cmd_ready;
  logic               r_in_ready;
  logic               r_core_start;
  logic               r_digest_valid;
  logic               r_err;
  logic [7:0]         r_buf [0:MAX_LEN-1];

  logic               w_cmd_hs;
  logic               w_in_hs;
  logic               w_consume;
  logic               w_len_bad;
  logic               w_len_zero;
  logic               w_wr_last;
  logic               w_rd_last;
  logic               w_hash_last;
  logic               w_timeout;

  assign w_cmd_hs    = cmd_valid & r_cmd_ready;
  assign w_in_hs     = in_valid & r_in_ready;
  assign w_consume   = (r_state == S_LOAD) & ~core_busy;
  assign w_len_bad   = (cmd_len > MAX_LEN_L);
  assign w_len_zero  = (cmd_len == '0);
  // Length compares use the full 12-bit latched length.
  assign w_wr_last   = ({{(LEN_W-IDX_W){1'b0}}, r_wr_idx} == (r_len - 12'd1));
  assign w_rd_last   = ({{(LEN_W-IDX_W){1'b0}}, r_rd_idx} == (r_len - 12'd1));
  assign w_hash_last = core_valid & (r_hash_cnt == HC_LAST);
  assign w_timeout   = ~core_valid & (r_to_cnt == TO_LAST);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_cmd_hs && !w_len_bad) w_nxt = w_len_zero ? S_START : S_FILL;
      S_FILL:      if (w_in_hs && w_wr_last) w_nxt = S_START;
      S_START:     w_nxt = (r_len == '0) ? S_WAIT_HASH : S_LOAD;
      S_LOAD:      if (w_consume && w_rd_last) w_nxt = S_WAIT_HASH;
      S_WAIT_HASH: begin
        if (w_hash_last)    w_nxt = S_DONE;
        else if (w_timeout) w_nxt = S_IDLE;
      end
      S_DONE:      if (digest_ack) w_nxt = S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_hash_cnt     <= '0;
      r_to_cnt       <= '0;
      r_digest       <= '0;
      r_cmd_ready    <= 1'b0;
      r_in_ready     <= 1'b0;
      r_core_start   <= 1'b0;
      r_digest_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_nxt;
      r_cmd_ready    <= (w_nxt == S_IDLE);
      r_in_ready     <= (w_nxt == S_FILL);
      r_core_start   <= (w_nxt == S_START);
      r_digest_valid <= (w_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_len      <= cmd_len;
            r_err      <= w_len_bad;
            r_digest   <= '0;
            r_hash_cnt <= '0;
            r_to_cnt   <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
          end
        end
        S_FILL: begin
          if (w_in_hs) r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
        S_START: begin
          r_rd_idx <= '0;
        end
        S_LOAD: begin
          if (w_consume) r_rd_idx <= r_rd_idx + IDX_W'(1);
        end
        S_WAIT_HASH: begin
          if (core_valid) begin
            r_digest   <= {r_digest[DIG_W-9:0], core_hash};
            r_hash_cnt <= r_hash_cnt + HC_W'(1);
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Message buffer holds data only; its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_wr_idx[ADDR_W-1:0]] <= in_data;
  end

  assign cmd_ready    = r_cmd_ready;
  assign in_ready     = r_in_ready;
  assign core_start   = r_core_start;
  assign core_msg_len = r_len;
  assign core_msg     = (r_state == S_LOAD) ? r_buf[r_rd_idx[ADDR_W-1:0]] : 8'h00;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_xoodyak_host_adapter.sv
// Randomized scoreboard bench for xoodyak_host_adapter; the bench plays both the
// host front end and the hash core.
module tb_xoodyak_host_adapter;

  localparam int MAX_LEN    = 64;
  localparam int HASH_BYTES = 32;
  localparam int TIMEOUT    = 4096;

  logic         clk;
  logic         resetn;
  logic         cmd_valid;
  logic [11:0]  cmd_len;
  logic         cmd_ready;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         core_start;
  logic [11:0]  core_msg_len;
  logic [7:0]   core_msg;
  logic         core_busy;
  logic [7:0]   core_hash;
  logic         core_valid;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ack;
  logic         err;

  xoodyak_host_adapter #(
    .MAX_LEN(MAX_LEN), .HASH_BYTES(HASH_BYTES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_start(core_start), .core_msg_len(core_msg_len), .core_msg(core_msg),
    .core_busy(core_busy), .core_hash(core_hash), .core_valid(core_valid),
    .digest(digest), .digest_valid(digest_valid), .digest_ack(digest_ack),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0]  exp_len_q[$];
  logic [7:0]   exp_byte_q[$];
  logic [255:0] exp_digest_q[$];
  logic [255:0] last_digest = '0;
  logic [7:0]   hq[$];

  int busy_mode   = 0;
  bit hash_silent = 0;
  bit stray_valid = 0;
  int n_consumed  = 0;
  int phase       = 0;
  int remaining   = 0;
  int hold_cnt    = 0;
  bit dv_seen     = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Digest = hash bytes in arrival order, first byte most significant.
  function automatic logic [255:0] ref_digest(input logic [7:0] b[$]);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < HASH_BYTES; i++) d[255-8*i -: 8] = b[i];
    return d;
  endfunction

  // Core model: checks start/length and every consumed byte, then returns hash beats.
  initial begin : core_model
    core_busy  = 1'b0;
    core_valid = 1'b0;
    core_hash  = 8'h00;
    forever begin
      @(negedge clk);
      core_valid = 1'b0;
      if (!resetn) begin
        phase     = 0;
        remaining = 0;
        core_busy = 1'b0;
        exp_byte_q.delete();
      end else begin
        case (phase)
          0: begin
            core_busy = 1'b0;
            if (core_start) begin
              if (exp_len_q.size() == 0) fail_now("core_start_unexpected");
              else chk("core_msg_len", 256'(core_msg_len), 256'(exp_len_q.pop_front()));
              remaining  = int'(core_msg_len);
              n_consumed = 0;
              hold_cnt   = 0;
              hq.delete();
              phase = (remaining == 0) ? 2 : 1;
            end else if (stray_valid) begin
              core_valid = 1'($urandom_range(0, 1));
              core_hash  = 8'($urandom);
            end
          end
          1: begin
            chk("core_start_in_load", 256'(core_start), 256'(0));
            case (busy_mode)
              1: core_busy = ~core_busy;
              2: core_busy = 1'($urandom_range(0, 1));
              3: begin
                if (n_consumed == 1 && hold_cnt < 2) begin
                  core_busy = 1'b1;
                  hold_cnt++;
                end else core_busy = 1'b0;
              end
              default: core_busy = 1'b0;
            endcase
            if (exp_byte_q.size() == 0) begin
              fail_now("core_msg_overrun");
              phase = 0;
            end else if (core_busy) begin
              chk("core_msg_hold", 256'(core_msg), 256'(exp_byte_q[0]));
            end else begin
              chk("core_msg", 256'(core_msg), 256'(exp_byte_q.pop_front()));
              n_consumed++;
              remaining--;
              if (remaining == 0) phase = 2;
            end
          end
          default: begin
            core_busy = 1'b0;
            chk("core_start_in_hash", 256'(core_start), 256'(0));
            if (hash_silent) begin
              if (err) phase = 0;
            end else if ($urandom_range(0, 2) != 0) begin
              core_valid = 1'b1;
              core_hash  = 8'($urandom);
              hq.push_back(core_hash);
              if (hq.size() == HASH_BYTES) begin
                last_digest = ref_digest(hq);
                exp_digest_q.push_back(last_digest);
                phase = 0;
              end
            end
          end
        endcase
      end
    end
  end

  // Digest monitor: one comparison per digest_valid rising.
  initial begin : digest_monitor
    forever begin
      @(negedge clk);
      if (!resetn) dv_seen = 0;
      else if (digest_valid && !dv_seen) begin
        dv_seen = 1;
        if (exp_digest_q.size() == 0) fail_now("digest_unexpected");
        else chk("digest", digest, exp_digest_q.pop_front());
      end else if (!digest_valid) dv_seen = 0;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"},    256'(cmd_ready),    256'(0));
    chk({tag, "_in_ready"},     256'(in_ready),     256'(0));
    chk({tag, "_core_start"},   256'(core_start),   256'(0));
    chk({tag, "_core_msg_len"}, 256'(core_msg_len), 256'(0));
    chk({tag, "_core_msg"},     256'(core_msg),     256'(0));
    chk({tag, "_digest"},       digest,             256'(0));
    chk({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
    chk({tag, "_err"},          256'(err),          256'(0));
  endtask

  task automatic send_cmd(input int len);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) fail_now("cmd_ready_wait");
    else begin
      if (len <= MAX_LEN) exp_len_q.push_back(12'(len));
      cmd_valid = 1'b1;
      cmd_len   = 12'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (len > MAX_LEN) begin
        chk("err_on_overlong",        256'(err),       256'(1));
        chk("cmd_ready_after_reject", 256'(cmd_ready), 256'(1));
      end else begin
        chk("cmd_ready_drop", 256'(cmd_ready), 256'(0));
        chk("err_cleared",    256'(err),       256'(0));
      end
    end
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int gap_pct);
    int i = 0;
    int t = 0;
    while (i < q.size() && t < 4000) begin
      @(negedge clk);
      t++;
      in_valid = 1'b0;
      if (in_ready && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = q[i];
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (i < q.size()) fail_now("in_ready_wait");
    else chk("in_ready_after_last", 256'(in_ready), 256'(0));
  endtask

  task automatic wait_digest();
    int t = 0;
    while (!digest_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!digest_valid) fail_now("digest_wait");
    else begin
      cmd_valid = 1'b1;
      cmd_len   = 12'd0;
      repeat (3) begin
        @(negedge clk);
        chk("digest_valid_hold", 256'(digest_valid), 256'(1));
        chk("cmd_ready_in_done", 256'(cmd_ready),    256'(0));
      end
      cmd_valid  = 1'b0;
      digest_ack = 1'b1;
      @(negedge clk);
      digest_ack = 1'b0;
      chk("digest_valid_after_ack", 256'(digest_valid), 256'(0));
      chk("cmd_ready_after_ack",    256'(cmd_ready),    256'(1));
      chk("digest_retained",        digest,             last_digest);
    end
  endtask

  task automatic make_msg(input int len, input bit fixed, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < len; i++) q.push_back(fixed ? 8'(i) : 8'($urandom));
    foreach (q[i]) exp_byte_q.push_back(q[i]);
  endtask

  task automatic run_msg(input int len, input int busy, input int gap, input bit fixed);
    logic [7:0] q[$];
    busy_mode = busy;
    make_msg(len, fixed, q);
    send_cmd(len);
    if (len > 0) send_bytes(q, gap);
    wait_digest();
  endtask

  initial begin : stimulus
    logic [7:0] q[$];
    int t;
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_len    = 12'd0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    digest_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;

    run_msg(0, 0, 0, 1);
    run_msg(3, 3, 50, 1);
    run_msg(39, 1, 0, 1);

    send_cmd(65);
    repeat (4) @(negedge clk);
    chk("err_sticky", 256'(err), 256'(1));
    run_msg(2, 2, 20, 0);
    run_msg(MAX_LEN, 2, 10, 0);

    // Silent core after the message: timeout abort, then stray beats in IDLE.
    hash_silent = 1;
    busy_mode   = 0;
    make_msg(4, 0, q);
    send_cmd(4);
    send_bytes(q, 0);
    t = 0;
    while (!err && t < TIMEOUT + 200) begin
      @(negedge clk);
      t++;
    end
    if (!err) fail_now("timeout_err");
    else begin
      chk("timeout_window", 256'((t >= TIMEOUT - 16 && t <= TIMEOUT + 16) ? 1 : 0), 256'(1));
      chk("timeout_digest_valid", 256'(digest_valid), 256'(0));
      chk("timeout_cmd_ready",    256'(cmd_ready),    256'(1));
    end
    @(negedge clk);
    hash_silent = 0;
    stray_valid = 1;
    repeat (20) @(negedge clk);
    stray_valid = 0;
    @(negedge clk);
    chk("digest_after_stray",       digest,             256'(0));
    chk("digest_valid_after_stray", 256'(digest_valid), 256'(0));
    chk("err_after_stray",          256'(err),          256'(1));

    // Reset in the middle of LOAD.
    n_consumed = 0;
    busy_mode  = 0;
    make_msg(20, 0, q);
    send_cmd(20);
    send_bytes(q, 0);
    t = 0;
    while (n_consumed < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (n_consumed < 5) fail_now("load_progress");
    resetn = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(negedge clk);
    resetn = 1'b1;
    run_msg(2, 0, 0, 0);

    for (int k = 0; k < 4; k++) run_msg($urandom_range(1, MAX_LEN), 2, 30, 0);

    repeat (5) @(negedge clk);
    chk("exp_len_q_empty",    256'(exp_len_q.size()),    256'(0));
    chk("exp_byte_q_empty",   256'(exp_byte_q.size()),   256'(0));
    chk("exp_digest_q_empty", 256'(exp_digest_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
